// File: rtl/real_bits_port_arbiter.sv
// real_bits_port_arbiter: round-robin arbiter that grants one of N requesters,
// captures its 64-bit $realtobits pattern into a shadow register and streams
// it onto a LINK_W-bit link, least-significant beat first.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. valid never depends on ready. While valid
// is held without ready, the associated data/last/src stay stable. On the
// requester side req_ready is the grant and doubles as the capture strobe.
module real_bits_port_arbiter #(
  parameter int N      = 4,
  parameter int LINK_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [64*N-1:0]        req_bits,
  output logic [N-1:0]           req_ready,
  output logic                   link_valid,
  output logic [LINK_W-1:0]      link_data,
  output logic                   link_last,
  output logic [$clog2(N)-1:0]   link_src,
  input  logic                   link_ready,
  output logic                   busy
);

  localparam int BEATS = 64 / LINK_W;
  localparam int SW    = $clog2(N);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // busy is the externally visible copy of the state register.
  logic [0:0]    state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] src;
  logic [BW-1:0] beat;
  logic [63:0]   shadow;

  logic [SW-1:0] grant;
  logic [SW-1:0] next_ptr;
  logic [N-1:0]  grant_oh;
  logic          any_req;
  logic          capture;
  logic          beat_done;
  int            idx;

  // Rotating-priority search: first requester at or after ptr, wrapping at N.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req_valid[SW'(idx)]) grant = SW'(idx);
    end
  end

  // Grant strobe, pointer successor and link-side outputs.
  always_comb begin
    any_req   = |req_valid;
    grant_oh  = {{(N-1){1'b0}}, 1'b1} << grant;
    req_ready = (rst_n && (state == IDLE) && any_req) ? grant_oh : '0;
    capture   = |(req_valid & req_ready);
    next_ptr  = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;

    link_valid = (state == SEND);
    busy       = (state == SEND);
    beat_done  = link_valid && link_ready;
    link_data  = link_valid ? shadow[int'(beat) * LINK_W +: LINK_W] : '0;
    link_last  = link_valid && (beat == LAST_BEAT);
    link_src   = link_valid ? src : '0;
  end

  // State, pointer, shadow word and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      src    <= '0;
      beat   <= '0;
      shadow <= '0;
    end else if (capture) begin
      shadow <= req_bits[int'(grant) * 64 +: 64];
      src    <= grant;
      beat   <= '0;
      ptr    <= next_ptr;
      state  <= SEND;
    end else if (beat_done) begin
      if (beat == LAST_BEAT) state <= IDLE;
      else                   beat  <= beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_real_bits_port_arbiter.sv
// Directed bench for real_bits_port_arbiter: a 4-requester 32-bit-link
// instance plus a 2-requester 8-bit-link instance sharing clock and reset.
module tb_real_bits_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [3:0]   req_valid = '0;
  logic [255:0] req_bits = '0;
  logic [3:0]   req_ready;
  logic         link_valid;
  logic [31:0]  link_data;
  logic         link_last;
  logic [1:0]   link_src;
  logic         link_ready = 1'b1;
  logic         busy;

  logic [1:0]   req_valid8 = '0;
  logic [127:0] req_bits8 = '0;
  logic [1:0]   req_ready8;
  logic         link_valid8;
  logic [7:0]   link_data8;
  logic         link_last8;
  logic [0:0]   link_src8;
  logic         link_ready8 = 1'b1;
  logic         busy8;

  int errors = 0;
  int checks = 0;

  // Clock.
  always #5 clk = ~clk;

  real_bits_port_arbiter #(.N(4), .LINK_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bits(req_bits),
    .req_ready(req_ready), .link_valid(link_valid), .link_data(link_data),
    .link_last(link_last), .link_src(link_src), .link_ready(link_ready),
    .busy(busy)
  );

  real_bits_port_arbiter #(.N(2), .LINK_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid8), .req_bits(req_bits8),
    .req_ready(req_ready8), .link_valid(link_valid8), .link_data(link_data8),
    .link_last(link_last8), .link_src(link_src8), .link_ready(link_ready8),
    .busy(busy8)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL reset_link_valid: got %b exp 0", link_valid); end
    checks++; if (link_data !== 32'h0) begin errors++; $display("FAIL reset_link_data: got %h exp 0", link_data); end
    checks++; if (link_last !== 1'b0) begin errors++; $display("FAIL reset_link_last: got %b exp 0", link_last); end
    checks++; if (link_src !== 2'd0) begin errors++; $display("FAIL reset_link_src: got %0d exp 0", link_src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    @(negedge clk);
    link_ready = 1'b1;
    req_bits[64*1 +: 64] = 64'h3FF0000000000000;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    req_bits[64*1 +: 64] = 64'hDEADBEEFDEADBEEF;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_in_send: got %b exp 0000", req_ready); end
    checks++; if (link_valid !== 1'b1 || link_data !== 32'h00000000 || link_last !== 1'b0) begin errors++; $display("FAIL single_beat0: got v=%b d=%h l=%b exp v=1 d=00000000 l=0", link_valid, link_data, link_last); end
    checks++; if (link_src !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL single_src_busy: got src=%0d busy=%b exp src=1 busy=1", link_src, busy); end
    @(negedge clk);
    checks++; if (link_valid !== 1'b1 || link_data !== 32'h3FF00000 || link_last !== 1'b1) begin errors++; $display("FAIL single_beat1: got v=%b d=%h l=%b exp v=1 d=3ff00000 l=1", link_valid, link_data, link_last); end
    @(negedge clk);
    checks++; if (link_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got v=%b busy=%b exp 0 0", link_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src;
    for (int i = 0; i < 4; i++) req_bits[64*i +: 64] = {32'hA0000000 | i, 32'h50000000 | i};
    @(negedge clk);
    link_ready = 1'b1;
    req_valid = 4'b1111;
    for (int w = 0; w < 6; w++) begin
      exp_src = 2'(w % 4);
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_src)) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", w, req_ready, 4'b0001 << exp_src); end
      @(negedge clk);
      checks++; if (link_valid !== 1'b1 || link_src !== exp_src || link_data !== (32'h50000000 | 32'(exp_src))) begin errors++; $display("FAIL rr_beat0_%0d: got v=%b src=%0d d=%h exp src=%0d", w, link_valid, link_src, link_data, exp_src); end
      @(negedge clk);
      checks++; if (link_last !== 1'b1 || link_data !== (32'hA0000000 | 32'(exp_src))) begin errors++; $display("FAIL rr_beat1_%0d: got l=%b d=%h", w, link_last, link_data); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_priority_rotation();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL prio_req2: got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL prio_3_before_0: got %b exp 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checks++; if (link_src !== 2'd3) begin errors++; $display("FAIL prio_src3: got %0d exp 3", link_src); end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL prio_then_0: got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    req_bits[64*1 +: 64] = 64'hC00921FB54442D18;
    req_valid = 4'b0010;
    link_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (link_valid !== 1'b1 || link_data !== 32'h54442D18 || link_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b exp v=1 d=54442d18 l=0", k, link_valid, link_data, link_last); end
      if (k < 3) @(negedge clk);
    end
    link_ready = 1'b1;
    @(negedge clk);
    checks++; if (link_valid !== 1'b1 || link_data !== 32'hC00921FB || link_last !== 1'b1) begin errors++; $display("FAIL bp_beat1: got v=%b d=%h l=%b exp v=1 d=c00921fb l=1", link_valid, link_data, link_last); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (link_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ready_no_effect: got v=%b busy=%b exp 0 0", link_valid, busy); end
  endtask

  task automatic test_reset_mid_word();
    req_bits[64*2 +: 64] = 64'h400921FB54442D18;
    req_valid = 4'b0100;
    link_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_mid_grant: got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if (link_valid !== 1'b1 || link_data !== 32'h400921FB) begin errors++; $display("FAIL rst_mid_beat1: got v=%b d=%h exp v=1 d=400921fb", link_valid, link_data); end
    rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    checks++; if (link_valid !== 1'b0 || link_last !== 1'b0 || link_data !== 32'h0) begin errors++; $display("FAIL rst_mid_link: got v=%b l=%b d=%h exp all 0", link_valid, link_last, link_data); end
    checks++; if (link_src !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_misc: got src=%0d busy=%b rdy=%b exp 0 0 0000", link_src, busy, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_ptr0: got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_link_w8();
    logic [7:0] exp_b [8];
    exp_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    req_bits8[63:0] = 64'h0123456789ABCDEF;
    req_valid8 = 2'b01;
    link_ready8 = 1'b1;
    #1;
    checks++; if (req_ready8 !== 2'b01) begin errors++; $display("FAIL w8_grant: got %b exp 01", req_ready8); end
    @(negedge clk);
    req_valid8 = '0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (link_valid8 !== 1'b1 || link_data8 !== exp_b[i] || link_last8 !== (i == 7)) begin errors++; $display("FAIL w8_beat%0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, link_valid8, link_data8, link_last8, exp_b[i], (i == 7)); end
      @(negedge clk);
    end
    checks++; if (link_valid8 !== 1'b0) begin errors++; $display("FAIL w8_done: got %b exp 0", link_valid8); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence and summary.
  initial begin
    test_reset();
    test_single_word();
    do_reset();
    test_round_robin();
    test_priority_rotation();
    test_backpressure();
    test_reset_mid_word();
    test_link_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
